// File: rtl/ps2_scancode_decoder_if.sv
// Byte-stream input and key-state output bundle of the PS/2 scan code decoder.
interface ps2_scancode_decoder_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_err;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         busy;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  key_down, last_change, key_valid, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output key_down, last_change, key_valid, busy
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Turns scan code set 2 bytes into a held-key vector, last changed key and change strobe.
// Handles E0/F0 prefixes, the E1 Pause sequence, receiver errors and stalled sequences.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter bit REPORT_REPEAT  = 1'b0,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_scancode_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t         state, state_next;
  logic [TW-1:0]  tmo_cnt;
  logic [SW-1:0]  skip_cnt, skip_next;
  logic [511:0]   key_down;
  logic [8:0]     last_change;
  logic           key_valid;
  logic           do_make, do_break, do_clear;
  logic [8:0]     key_idx;
  logic           expire, fake_shift, reset_code;

  assign expire     = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fake_shift = (bus.rx_data == 8'h12) || (bus.rx_data == 8'h59);
  assign reset_code = (bus.rx_data == 8'h00) || (bus.rx_data == 8'hFF) ||
                      (bus.rx_data == 8'hAA) || (bus.rx_data == 8'hFC);

  // A receiver error beats a coincident byte, and a byte beats a coincident timeout.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    do_make    = 1'b0;
    do_break   = 1'b0;
    do_clear   = 1'b0;
    key_idx    = {(state == EXT) || (state == EXT_BRK), bus.rx_data};
    if (bus.rx_err) begin
      state_next = IDLE;
      skip_next  = '0;
    end else if (bus.rx_valid) begin
      case (state)
        IDLE: begin
          if (bus.rx_data == 8'hE0)      state_next = EXT;
          else if (bus.rx_data == 8'hF0) state_next = BRK;
          else if (bus.rx_data == 8'hE1) begin
            state_next = SKIP;
            skip_next  = SW'(PAUSE_SKIP);
          end
          else if (reset_code)           do_clear = 1'b1;
          else                           do_make  = 1'b1;
        end
        EXT: begin
          if (bus.rx_data == 8'hF0)      state_next = EXT_BRK;
          else if (bus.rx_data == 8'hE0) state_next = EXT;
          else begin
            state_next = IDLE;
            do_make    = !fake_shift;
          end
        end
        BRK: begin
          if (bus.rx_data == 8'hF0)      state_next = BRK;
          else if (bus.rx_data == 8'hE0) state_next = EXT;
          else begin
            state_next = IDLE;
            do_break   = 1'b1;
          end
        end
        EXT_BRK: begin
          state_next = IDLE;
          do_break   = !fake_shift;
        end
        SKIP: begin
          skip_next = skip_cnt - SW'(1);
          if (skip_cnt <= SW'(1)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (expire) begin
      state_next = IDLE;
      skip_next  = '0;
    end
  end

  // The inter-byte timer only runs mid-sequence and restarts on every byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      if (state_next == IDLE || bus.rx_valid) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_down    <= '0;
      last_change <= 9'h000;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (do_clear) begin
        key_down <= '0;
      end else if (do_make) begin
        key_down[key_idx] <= 1'b1;
        if (!key_down[key_idx] || REPORT_REPEAT) begin
          last_change <= key_idx;
          key_valid   <= 1'b1;
        end
      end else if (do_break && key_down[key_idx]) begin
        key_down[key_idx] <= 1'b0;
        last_change       <= key_idx;
        key_valid         <= 1'b1;
      end
    end
  end

  assign bus.key_down    = key_down;
  assign bus.last_change = last_change;
  assign bus.key_valid   = key_valid;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Drives two decoders (repeats suppressed / reported) with directed and random byte
// streams and compares them with a sequence-level reference model.
module tb_ps2_scancode_decoder;

  localparam int TMO   = 40;
  localparam int SKIPN = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ps2_scancode_decoder_if bus0();
  ps2_scancode_decoder_if bus1();

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .REPORT_REPEAT(1'b0), .PAUSE_SKIP(SKIPN))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .REPORT_REPEAT(1'b1), .PAUSE_SKIP(SKIPN))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [511:0] m_keys  [2];
  logic [8:0]   m_last  [2];
  logic         m_valid [2];
  bit           rep     [2] = '{1'b0, 1'b1};
  bit           m_ext, m_brk, m_seq;
  int           m_skip, m_idle;
  int           pulses  [2];

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_keys[i]  = '0;
      m_last[i]  = 9'h000;
      m_valid[i] = 1'b0;
    end
    m_ext = 0; m_brk = 0; m_seq = 0; m_skip = 0; m_idle = 0;
  endtask

  task automatic modelKey(input logic [8:0] k, input bit is_make);
    for (int i = 0; i < 2; i++) begin
      if (is_make) begin
        if (!m_keys[i][k] || rep[i]) begin
          m_last[i]  = k;
          m_valid[i] = 1'b1;
        end
        m_keys[i][k] = 1'b1;
      end else if (m_keys[i][k]) begin
        m_keys[i][k] = 1'b0;
        m_last[i]    = k;
        m_valid[i]   = 1'b1;
      end
    end
  endtask

  // Sequence-level interpretation: prefixes accumulate, the first non-prefix byte completes.
  task automatic modelByte(input logic [7:0] b, input bit err);
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    m_idle = 0;
    if (err) begin
      m_ext = 0; m_brk = 0; m_seq = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
      m_seq = (m_skip > 0);
    end else if (!m_seq && b == 8'hE1) begin
      m_skip = SKIPN;
      m_seq  = 1;
    end else if (!m_seq && (b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFC)) begin
      m_keys[0] = '0;
      m_keys[1] = '0;
    end else if (!(m_ext && m_brk) && b == 8'hE0) begin
      m_ext = 1; m_brk = 0; m_seq = 1;
    end else if (!(m_ext && m_brk) && b == 8'hF0) begin
      m_brk = 1; m_seq = 1;
    end else begin
      if (!(m_ext && (b == 8'h12 || b == 8'h59))) modelKey({m_ext, b}, !m_brk);
      m_ext = 0; m_brk = 0; m_seq = 0;
    end
  endtask

  task automatic checkAll(input string tag, input bit chk_busy);
    checkOutput($sformatf("%s valid0", tag), 512'(bus0.key_valid), 512'(m_valid[0]));
    checkOutput($sformatf("%s valid1", tag), 512'(bus1.key_valid), 512'(m_valid[1]));
    checkOutput($sformatf("%s last0", tag), 512'(bus0.last_change), 512'(m_last[0]));
    checkOutput($sformatf("%s last1", tag), 512'(bus1.last_change), 512'(m_last[1]));
    checkOutput($sformatf("%s keys0", tag), bus0.key_down, m_keys[0]);
    checkOutput($sformatf("%s keys1", tag), bus1.key_down, m_keys[1]);
    if (chk_busy) begin
      checkOutput($sformatf("%s busy0", tag), 512'(bus0.busy), 512'(m_seq));
      checkOutput($sformatf("%s busy1", tag), 512'(bus1.busy), 512'(m_seq));
    end
  endtask

  // Called at a falling edge; presents one byte for one cycle and checks the result.
  task automatic applyStimulus(input logic [7:0] b, input bit err);
    bus0.rx_data = b;    bus1.rx_data = b;
    bus0.rx_valid = 1;   bus1.rx_valid = 1;
    bus0.rx_err = err;   bus1.rx_err = err;
    @(posedge clk);
    @(negedge clk);
    bus0.rx_valid = 0;   bus1.rx_valid = 0;
    bus0.rx_err = 0;     bus1.rx_err = 0;
    modelByte(b, err);
    pulses[0] += int'(bus0.key_valid);
    pulses[1] += int'(bus1.key_valid);
    checkAll($sformatf("byte %02h err %0d", b, err), 1'b1);
  endtask

  // Exact expiry cycle is left unchecked; busy is verified well before and after it.
  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      m_idle++;
      if (m_seq && m_idle >= TMO) begin
        m_ext = 0; m_brk = 0; m_seq = 0; m_skip = 0;
      end
      checkAll("idle", !(m_idle >= TMO - 1 && m_idle <= TMO + 1));
    end
  endtask

  task automatic errCycle();
    bus0.rx_err = 1; bus1.rx_err = 1;
    @(posedge clk);
    @(negedge clk);
    bus0.rx_err = 0; bus1.rx_err = 0;
    modelByte(8'h00, 1'b1);
    checkAll("err", 1'b1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] pool [12];
    logic [7:0] b;
    int r;
    pool = '{8'h1C, 8'h1D, 8'h23, 8'h75, 8'h12, 8'h59, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h5A, 8'h6B};
    bus0.rx_data = 0; bus0.rx_valid = 0; bus0.rx_err = 0;
    bus1.rx_data = 0; bus1.rx_valid = 0; bus1.rx_err = 0;
    pulses[0] = 0; pulses[1] = 0;
    modelReset();
    #12;
    checkAll("reset", 1'b1);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(8'h1C, 0);
    checkOutput("make 1C bit", 512'(bus0.key_down[9'h01C]), 512'(1'b1));
    checkOutput("make 1C last", 512'(bus0.last_change), 512'(9'h01C));
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h1C, 0);
    checkOutput("break 1C bit", 512'(bus0.key_down[9'h01C]), 512'(1'b0));
    checkOutput("break 1C pulse", 512'(bus0.key_valid), 512'(1'b1));

    applyStimulus(8'hE0, 0);
    applyStimulus(8'h75, 0);
    checkOutput("make 175 bit", 512'(bus0.key_down[9'h175]), 512'(1'b1));
    applyStimulus(8'hE0, 0);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h75, 0);
    checkOutput("break 175 bit", 512'(bus0.key_down[9'h175]), 512'(1'b0));
    checkOutput("075 untouched", 512'(bus0.key_down[9'h075]), 512'(1'b0));
    idleCycles(2);

    pulses[0] = 0; pulses[1] = 0;
    for (int i = 0; i < 3; i++) applyStimulus(8'h1D, 0);
    checkOutput("repeat pulses off", 512'(pulses[0]), 512'(1));
    checkOutput("repeat pulses on", 512'(pulses[1]), 512'(3));

    applyStimulus(8'h1C, 0);
    applyStimulus(8'h23, 0);
    applyStimulus(8'hAA, 0);
    checkOutput("AA clears", bus1.key_down, 512'(0));

    pulses[0] = 0; pulses[1] = 0;
    applyStimulus(8'hE1, 0);
    for (int i = 0; i < SKIPN; i++) applyStimulus(8'($urandom), 0);
    checkOutput("pause silent", 512'(pulses[0] + pulses[1]), 512'(0));
    applyStimulus(8'h1B, 0);
    checkOutput("after pause last", 512'(bus0.last_change), 512'(9'h01B));

    applyStimulus(8'hF0, 0);
    idleCycles(TMO / 2);
    idleCycles(TMO);
    applyStimulus(8'h1C, 0);
    checkOutput("timeout then make", 512'(bus0.key_down[9'h01C]), 512'(1'b1));

    applyStimulus(8'hF0, 0);
    applyStimulus(8'h1C, 0);
    applyStimulus(8'hF0, 0);
    errCycle();
    applyStimulus(8'h1C, 0);
    checkOutput("err then make", 512'(bus0.key_down[9'h01C]), 512'(1'b1));
    applyStimulus(8'hE0, 0);
    applyStimulus(8'h75, 1);
    checkOutput("err drops byte", 512'(bus0.key_down[9'h175]), 512'(1'b0));

    applyStimulus(8'hE0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async keys", bus0.key_down, 512'(0));
    checkOutput("async busy", 512'(bus0.busy), 512'(0));
    checkOutput("async last", 512'(bus1.last_change), 512'(0));
    checkOutput("async valid", 512'(bus1.key_valid), 512'(0));
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'h75, 0);
    checkOutput("post reset last", 512'(bus0.last_change), 512'(9'h075));

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 80) b = pool[$urandom_range(0, 11)];
      else        b = 8'($urandom);
      applyStimulus(b, ($urandom_range(0, 29) == 0));
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Converts the byte stream from the PS/2 receiver (scan code set 2) into the key-state interface used by all keyboard-driven controllers: a 512-bit held-key vector, the 9-bit code of the last changed key, and a one-cycle change strobe.
- Sits between the PS/2 byte receiver and the volume/octave, note and mode controllers.
- Handles E0 extension prefixes, F0 break prefixes, the E1 Pause sequence, receiver errors, stalled sequences and keyboard reset/overflow codes.

Parameters:
- TIMEOUT_CYCLES, 2000000, clk cycles allowed between bytes of a multi-byte sequence before it is abandoned (20 ms at 100 MHz).
- REPORT_REPEAT, 0, 1 = typematic repeat makes of an already-held key pulse key_valid; 0 = repeats are suppressed.
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte; valid only while rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- rx_err  input  1  one-cycle strobe on a parity/framing/stop-bit error from the receiver
- key_down  output  512  bit {ext,code} = 1 while that key is held
- last_change  output  9  {ext,code} of the most recent reported make/break
- key_valid  output  1  one-cycle strobe; key_down and last_change are coherent with it
- busy  output  1  high while a multi-byte sequence is in progress (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous):
  - key_down=0, last_change=9'h000, key_valid=0, busy=0.
  - State=IDLE; timeout counter and skip counter cleared.
  - Reset asserted mid-sequence discards the partial sequence.
- Key index: {ext, byte}. ext=1 when the sequence began with E0. Example: A = 9'h01C, keypad Enter = 9'h15A.
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 sequence).
- Transitions on rx_valid from IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, skip counter = PAUSE_SKIP.
  - 00, FF, AA or FC -> key_down cleared to 0; no key_valid; stay IDLE.
  - Any other byte b -> make of {0,b}.
- Transitions on rx_valid from EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - 12 or 59 (fake shift) -> IDLE, no effect.
  - Other byte b -> make of {1,b}, then IDLE.
- Transitions on rx_valid from BRK:
  - F0 -> stay BRK.
  - E0 -> EXT.
  - Other byte b -> break of {0,b}, then IDLE.
- Transitions on rx_valid from EXT_BRK:
  - 12 or 59 -> IDLE, no effect.
  - Other byte b -> break of {1,b}, then IDLE.
- SKIP: each rx_valid decrements the skip counter; at 0 -> IDLE. No key_down change, no key_valid.
- Make of key k:
  - Set key_down[k] and last_change<=k.
  - key_valid=1 on the clock edge after the final byte's rx_valid (1-cycle latency).
  - If key_down[k] was already 1 and REPORT_REPEAT=0: no key_valid and no last_change update.
- Break of key k:
  - If key_down[k]=1: clear it, last_change<=k, key_valid=1 (same latency).
  - If key_down[k]=0: no change, no strobe.
- key_valid is high for exactly one cycle and never on two consecutive cycles from one byte.
- Timeout counter:
  - Runs only while state != IDLE and is reloaded by every rx_valid.
  - On reaching TIMEOUT_CYCLES -> IDLE with no effect.
  - rx_valid in the same cycle as expiry is processed normally; the byte wins.
- rx_err in any state -> IDLE with the partial sequence discarded; key_down unchanged. If rx_err and rx_valid coincide, rx_err wins and the byte is dropped.
- Multiple keys may be held at once; each bit is independent. Only the 512-bit vector retains history.

Test Plan:
- 1C; then F0,1C -> key_down[9'h01C]=1 with key_valid pulse and last_change=9'h01C one cycle after the 1C strobe; after the break, bit cleared, second pulse, last_change=9'h01C.
- E0,75 then E0,F0,75 -> bit 9'h175 set then cleared, two key_valid pulses, bit 9'h075 never touched.
- REPORT_REPEAT=0, bytes 1D,1D,1D -> exactly one key_valid pulse. REPORT_REPEAT=1 -> three pulses, key_down[9'h01D]=1 throughout.
- Hold 1C and 23, then byte AA -> key_down all zero, no key_valid. E1 followed by 7 arbitrary bytes, then 1B -> only the 1B make is reported.
- F0, then no byte for TIMEOUT_CYCLES -> busy falls, state IDLE; next byte 1C is treated as a make, not a break. Repeat with rx_err after F0 -> same result.
- Assert rst=0 asynchronously mid-clock between E0 and 75 with keys held -> all outputs 0 immediately. After release, byte 75 is reported as make of 9'h075.
